smvm_result_collector: RTL and testbench

Downstream stage of the SMVM core. Captures the 24-bit per-row results that the core emits on `out_valid`/`data_out`, which carry no backpressure, and tags each result with its row index. Results are buffered in a small FIFO and drained through a valid/ready interface to the host/readout logic. The block raises `done` once the expected number of rows has been delivered.

---
 rtl/smvm_pkg.sv | 22 ++
 rtl/smvm_sync_fifo.sv | 60 ++++++
 rtl/smvm_result_collector.sv | 122 ++++++++++++
 tb/tb_smvm_result_collector.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// Shared definitions for the SMVM core and its downstream stages.
//   SMVM_DW / SMVM_RW : result and row-index widths of the core
//   collector_state_e : result collector job state
//   smvm_entry_t      : tagged result entry {row, data}
package smvm_pkg;

  localparam int unsigned SMVM_DW = 24;
  localparam int unsigned SMVM_RW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_FINISH  = 2'd3
  } collector_state_e;

  typedef struct packed {
    logic [SMVM_RW-1:0] row;
    logic [SMVM_DW-1:0] data;
  } smvm_entry_t;

endpackage

// File: rtl/smvm_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered memory.
//   clk, rst      : clock, synchronous active-high reset (flushes pointers)
//   push, din     : write request and data; a push while full is dropped unless
//                   a pop happens in the same cycle
//   pop, dout     : read request and head data (dout reads 0 while empty)
//   full, empty   : occupancy flags
//   one_left      : exactly one entry stored
module smvm_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (wrapped) from empty (equal).
  assign occ      = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign one_left = (occ == PW'(1));

  // A pop frees the slot the push lands in, so full+push+pop is accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/smvm_result_collector.sv
// Collects per-row SMVM results (no backpressure to the core), tags them with
// their row index, buffers them and drains them over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   start, num_rows     : arm a job for num_rows results (sampled in IDLE only)
//   in_valid, in_data   : result stream from the core
//   out_valid/out_ready : head handshake; out_data, out_row, out_last describe the head
//   busy                : job in progress
//   done                : one-cycle pulse at job completion
//   overflow            : sticky, a result was dropped on a full FIFO
module smvm_result_collector
  import smvm_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = SMVM_DW,
  parameter int unsigned RW    = SMVM_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] num_rows,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int unsigned EW = RW + DW;

  collector_state_e state;
  logic [RW-1:0]    row_cnt;
  logic [RW-1:0]    row_cnt_inc;
  logic [RW-1:0]    num_rows_q;
  logic [EW-1:0]    fifo_din;
  logic [EW-1:0]    fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_one_left;

  assign row_cnt_inc = row_cnt + RW'(1);
  assign fifo_push   = (state == ST_COLLECT) && in_valid;
  assign fifo_pop    = out_valid && out_ready;
  assign fifo_din    = {row_cnt, in_data};

  assign out_valid = !fifo_empty;
  assign out_row   = fifo_dout[EW-1:DW];
  assign out_data  = fifo_dout[DW-1:0];
  assign out_last  = out_valid && (out_row == RW'(num_rows_q - RW'(1)));

  smvm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (fifo_din),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left)
  );

  // Job FSM with registered busy/done/overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_cnt    <= '0;
      num_rows_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_rows != '0) begin
              num_rows_q <= num_rows;
              row_cnt    <= '0;
              overflow   <= 1'b0;
              state      <= ST_COLLECT;
            end else begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          // Count advances even on a drop so later tags stay aligned.
          if (in_valid) begin
            row_cnt <= row_cnt_inc;
            if (fifo_full && !fifo_pop) overflow <= 1'b1;
            if (row_cnt_inc == num_rows_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Look ahead on the last pop so done lands one cycle after it.
          if (fifo_empty || (fifo_pop && fifo_one_left)) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_result_collector.sv
module tb_smvm_result_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 24;
  localparam int unsigned RW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: job phase, stored entries {row,data}, sticky overflow.
  int          m_phase = 0;  // 0 idle, 1 collecting, 2 draining, 3 finishing
  int          m_num   = 0;
  int          m_rows  = 0;
  logic        m_ovf   = 1'b0;
  logic [31:0] m_q[$];
  logic [31:0] got[$];

  smvm_result_collector #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_rows  (num_rows),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] obs_vec();
    return {out_valid, out_row, out_data, out_last, busy, done, overflow};
  endfunction

  function automatic logic [36:0] exp_vec();
    logic        v;
    logic [31:0] h;
    logic        last;
    v    = (m_q.size() > 0);
    h    = v ? m_q[0] : 32'h0;
    last = v && (int'(h[31:24]) == m_num - 1);
    return {v, h, last, (m_phase != 0), (m_phase == 3), m_ovf};
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    int   size0;
    logic pop;
    int   ph;
    size0 = m_q.size();
    pop   = (size0 > 0) && out_ready;
    ph    = m_phase;
    if (!rst && out_valid && out_ready) got.push_back({out_row, out_data});
    if (rst) begin
      m_q.delete();
      m_phase = 0; m_num = 0; m_rows = 0; m_ovf = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      case (ph)
        0: if (start) begin
             if (num_rows != 0) begin
               m_num = int'(num_rows); m_rows = 0; m_ovf = 1'b0; m_phase = 1;
             end else m_phase = 3;
           end
        1: if (in_valid) begin
             if (size0 == DEPTH && !pop) m_ovf = 1'b1;
             else m_q.push_back({8'(m_rows), in_data});
             m_rows++;
             if (m_rows == m_num) m_phase = 2;
           end
        2: if (m_q.size() == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (obs_vec() !== 37'h0) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", obs_vec(), 37'h0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    logic [23:0] vals[4];
    int dones = 0;
    vals[0] = 24'd10; vals[1] = 24'hFFFFFD; vals[2] = 24'd7; vals[3] = 24'd0;
    got.delete();
    out_ready = 1'b1; start = 1'b1; num_rows = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 4);
      in_data  = (i < 4) ? vals[i] : 24'h0;
      tick();
      if (done) dones++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL basic_count got=%0d exp=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {8'(i), vals[i]}) begin
        failures++; $display("FAIL basic_entry%0d got=%h exp=%h", i, got[i], {8'(i), vals[i]});
      end
    end
    checks++;
    if (dones != 1 || overflow !== 1'b0) begin
      failures++; $display("FAIL basic_done dones=%0d ovf=%b exp dones=1 ovf=0", dones, overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] vals[4];
    got.delete();
    out_ready = 1'b0; start = 1'b1; num_rows = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 4);
      if (i < 4) begin vals[i] = 24'($urandom); in_data = vals[i]; end
      out_ready = (i >= 7);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL backpressure_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL backpressure_count got=%0d exp=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {8'(i), vals[i]}) begin
        failures++; $display("FAIL backpressure_entry%0d got=%h exp=%h", i, got[i], {8'(i), vals[i]});
      end
    end
  endtask

  task automatic test_overflow();
    int dones = 0;
    got.delete();
    out_ready = 1'b0; start = 1'b1; num_rows = 8'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 24'(i + 1);
      tick();
      checks++;
      if (overflow !== (i >= 4) || obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL overflow_push%0d got=%h exp=%h", i + 1, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL overflow_drain%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (got.size() != 4 || dones != 1) begin
      failures++; $display("FAIL overflow_summary entries=%0d dones=%0d exp 4 and 1", got.size(), dones);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {8'(i), 24'(i + 1)}) begin
        failures++; $display("FAIL overflow_entry%0d got=%h exp=%h", i, got[i], {8'(i), 24'(i + 1)});
      end
    end
    // A new job clears the sticky flag.
    start = 1'b1; num_rows = 8'd1;
    tick();
    start = 1'b0;
    checks++;
    if (overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL overflow_clear got=%h exp=%h", obs_vec(), exp_vec());
    end
    in_valid = 1'b1; in_data = 24'($urandom);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL overflow_next%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_push_pop();
    got.delete();
    out_ready = 1'b0; start = 1'b1; num_rows = 8'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = (i < 6);
      in_data   = 24'($urandom);
      out_ready = (i >= 4);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL fullpp_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_row !== 8'd2) begin
          failures++; $display("FAIL fullpp_steady ovf=%b valid=%b row=%0d exp 0 1 2", overflow, out_valid, out_row);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 6) begin
      failures++; $display("FAIL fullpp_count got=%0d exp=6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i][31:24] !== 8'(i)) begin
        failures++; $display("FAIL fullpp_row%0d got=%0d exp=%0d", i, got[i][31:24], i);
      end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int dones = 0;
    got.delete();
    out_ready = 1'b1; start = 1'b1; num_rows = 8'd0; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL zero_done done=%b busy=%b valid=%b exp 1 1 0", done, busy, out_valid);
    end
    tick();
    checks++;
    if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
      failures++; $display("FAIL zero_after got=%h exp=%h", obs_vec(), exp_vec());
    end
    // Second start while collecting must be ignored.
    start = 1'b1; num_rows = 8'd3;
    tick();
    for (int i = 0; i < 9; i++) begin
      start    = (i == 1);
      num_rows = 8'd7;
      in_valid = (i < 3);
      in_data  = 24'($urandom);
      tick();
      if (done) dones++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL ignored_start_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (got.size() != 3 || dones != 1) begin
      failures++; $display("FAIL ignored_start_summary entries=%0d dones=%0d exp 3 and 1", got.size(), dones);
    end
  endtask

  task automatic test_reset_mid_job();
    out_ready = 1'b0; start = 1'b1; num_rows = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 24'($urandom);
      tick();
    end
    rst = 1'b1; in_data = 24'($urandom);
    tick();
    checks++;
    if (obs_vec() !== 37'h0) begin
      failures++; $display("FAIL midreset_values got=%h exp=%h", obs_vec(), 37'h0);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || done !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL midreset_after%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random_max_rows();
    int cyc = 0;
    start = 1'b1; num_rows = 8'd255;
    tick();
    start = 1'b0;
    while (m_phase != 0 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 24'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_cyc%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (m_phase != 0) begin
      failures++; $display("FAIL random_timeout phase=%0d exp=0 after %0d cycles", m_phase, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_zero_and_ignored_start();
    test_reset_mid_job();
    test_random_max_rows();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
